// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy level, almost-full/empty thresholds, optional FWFT output, flush and sticky error flags.
// Latency: flags and level update one clock after an accepted put/get; FWFT=0 read data is registered, FWFT=1 head word is combinational.
// Backpressure: put is refused while full (sets overrun), get is refused while empty (sets underrun); no same-cycle bypass.
module fifo_sync #(
    parameter int W      = 8,
    parameter int ORDER  = 4,
    parameter int AFULL  = 12,
    parameter int AEMPTY = 4,
    parameter int FWFT   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [W-1:0]     in,
    input  logic             put,
    output logic             full,
    output logic [W-1:0]     out,
    input  logic             get,
    output logic             empty,
    output logic [ORDER:0]   level,
    output logic             afull,
    output logic             aempty,
    output logic             overrun,
    output logic             underrun
);

    localparam int D = 1 << ORDER;

    // Threshold constants sized to the level register so comparisons stay width-matched.
    localparam logic [ORDER:0]   LVL_D      = (ORDER+1)'(D);
    localparam logic [ORDER:0]   LVL_AFULL  = (ORDER+1)'(AFULL);
    localparam logic [ORDER:0]   LVL_AEMPTY = (ORDER+1)'(AEMPTY);
    localparam logic [ORDER:0]   LVL_ONE    = (ORDER+1)'(1);
    localparam logic [ORDER-1:0] PTR_ONE    = ORDER'(1);

    logic [W-1:0]     ram [D];
    logic [ORDER-1:0] wp;
    logic [ORDER-1:0] rp;
    logic             do_put;
    logic             do_get;

    // Flags come only from the registered level, so there is no path from put/get to any flag.
    assign full   = (level == LVL_D);
    assign empty  = (level == '0);
    assign afull  = (level >= LVL_AFULL);
    assign aempty = (level <= LVL_AEMPTY);

    // Acceptance looks at pre-edge state only; a full FIFO refuses put even if a get frees a slot this cycle.
    assign do_put = put && !full;
    assign do_get = get && !empty;

    // Storage write; held off during reset and flush so an aborted or flushed cycle leaves no trace.
    always_ff @(posedge clock) begin
        if (!reset && !flush && do_put) begin
            ram[wp] <= in;
        end
    end

    // Pointers, level and sticky error flags; flush outranks put/get in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else if (flush) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (do_put) begin
                wp <= wp + PTR_ONE;
            end
            if (do_get) begin
                rp <= rp + PTR_ONE;
            end
            if (put && !do_put) begin
                overrun <= 1'b1;
            end
            if (get && !do_get) begin
                underrun <= 1'b1;
            end
            case ({do_put, do_get})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; value is stale but stable when empty.
            assign out = ram[rp];
        end else begin : g_reg
            logic [W-1:0] out_q;

            // Registered read: only an accepted get reloads the output; it holds across refusals and flush.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    out_q <= '0;
                end else if (!flush && do_get) begin
                    out_q <= ram[rp];
                end
            end

            assign out = out_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync.sv
module tb_fifo_sync;

    logic       clock = 1'b0;
    logic       reset;
    logic       flush, put, get;
    logic [7:0] in;
    logic       full, empty, afull, aempty, overrun, underrun;
    logic [7:0] out;
    logic [4:0] level;

    logic       f1_flush, f1_put, f1_get;
    logic [7:0] f1_in;
    logic       f1_full, f1_empty, f1_afull, f1_aempty, f1_overrun, f1_underrun;
    logic [7:0] f1_out;
    logic [4:0] f1_level;

    fifo_sync #(.W(8), .ORDER(4), .AFULL(12), .AEMPTY(4), .FWFT(0)) dut (
        .clock(clock), .reset(reset), .flush(flush), .in(in), .put(put),
        .full(full), .out(out), .get(get), .empty(empty), .level(level),
        .afull(afull), .aempty(aempty), .overrun(overrun), .underrun(underrun)
    );

    fifo_sync #(.W(8), .ORDER(4), .AFULL(12), .AEMPTY(4), .FWFT(1)) dut1 (
        .clock(clock), .reset(reset), .flush(f1_flush), .in(f1_in), .put(f1_put),
        .full(f1_full), .out(f1_out), .get(f1_get), .empty(f1_empty), .level(f1_level),
        .afull(f1_afull), .aempty(f1_aempty), .overrun(f1_overrun), .underrun(f1_underrun)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents queue (scoreboard), sticky flags and expected registered output.
    logic [7:0] sb[$];
    logic       m_ovr;
    logic       m_und;
    logic [7:0] m_out;

    typedef struct {
        logic       p;
        logic       g;
        logic       f;
        logic [7:0] d;
        int         lvl;
        logic       ovr;
        logic       und;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ovr = 1'b0;
        m_und = 1'b0;
        m_out = 8'h00;
    endtask

    task automatic check_state();
        int n;
        n = sb.size();
        chk("level",    32'(level),    32'(n));
        chk("empty",    32'(empty),    32'(n == 0));
        chk("full",     32'(full),     32'(n == 16));
        chk("afull",    32'(afull),    32'(n >= 12));
        chk("aempty",   32'(aempty),   32'(n <= 4));
        chk("overrun",  32'(overrun),  32'(m_ovr));
        chk("underrun", 32'(underrun), 32'(m_und));
        chk("out",      32'(out),      32'(m_out));
    endtask

    // One clock: drive, let the edge happen, update the model from pre-edge state, compare #1 later.
    task automatic cyc(input logic p, input logic g, input logic f, input logic [7:0] d);
        bit acc_p, acc_g;
        put   = p;
        get   = g;
        flush = f;
        in    = d;
        @(posedge clock);
        if (f) begin
            sb.delete();
            m_ovr = 1'b0;
            m_und = 1'b0;
        end else begin
            acc_p = p && (sb.size() < 16);
            acc_g = g && (sb.size() > 0);
            if (p && !acc_p) m_ovr = 1'b1;
            if (g && !acc_g) m_und = 1'b1;
            if (acc_g) m_out = sb.pop_front();
            if (acc_p) sb.push_back(d);
        end
        #1;
        put   = 1'b0;
        get   = 1'b0;
        flush = 1'b0;
        check_state();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{p:1'b0, g:1'b1, f:1'b0, d:8'h00, lvl:0, ovr:1'b0, und:1'b1};
        tbl[1] = '{p:1'b1, g:1'b1, f:1'b0, d:8'h33, lvl:1, ovr:1'b0, und:1'b1};
        tbl[2] = '{p:1'b1, g:1'b0, f:1'b0, d:8'h44, lvl:2, ovr:1'b0, und:1'b1};
        tbl[3] = '{p:1'b0, g:1'b1, f:1'b0, d:8'h00, lvl:1, ovr:1'b0, und:1'b1};
        tbl[4] = '{p:1'b1, g:1'b0, f:1'b1, d:8'h55, lvl:0, ovr:1'b0, und:1'b0};
        tbl[5] = '{p:1'b1, g:1'b0, f:1'b0, d:8'h66, lvl:1, ovr:1'b0, und:1'b0};
        tbl[6] = '{p:1'b0, g:1'b1, f:1'b0, d:8'h00, lvl:0, ovr:1'b0, und:1'b0};

        reset = 1'b1; flush = 1'b0; put = 1'b0; get = 1'b0; in = 8'h00;
        f1_flush = 1'b0; f1_put = 1'b0; f1_get = 1'b0; f1_in = 8'h00;
        model_reset();
        #23;
        check_state();
        chk("f1_empty_rst", 32'(f1_empty), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;

        // Short directed table: refused get, put+get at empty, flush with put, simple traffic.
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].p, tbl[i].g, tbl[i].f, tbl[i].d);
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_ovr", i), 32'(overrun), 32'(tbl[i].ovr));
            chk($sformatf("tbl%0d_und", i), 32'(underrun), 32'(tbl[i].und));
        end

        // Fill 0x01..0x10, one refused put, drain in order.
        cyc(0, 0, 1, 8'h00);
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 0, 0, 8'(i));
            if (i == 11) chk("afull_at_11", 32'(afull), 32'd0);
            if (i == 12) chk("afull_at_12", 32'(afull), 32'd1);
        end
        chk("full_at_16", 32'(full), 32'd1);
        cyc(1, 0, 0, 8'h99);
        chk("ovr_17th", 32'(overrun), 32'd1);
        chk("lvl_17th", 32'(level), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, 0, 8'h00);
            chk("drain_data", 32'(out), 32'(i));
            if (i == 11) chk("aempty_at_5", 32'(aempty), 32'd0);
            if (i == 12) chk("aempty_at_4", 32'(aempty), 32'd1);
        end
        chk("drained_empty", 32'(empty), 32'd1);

        // Put+get at level 5 keeps the level and the order.
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'(8'h20 + i));
        for (int i = 0; i < 6; i++) cyc(1, 1, 0, 8'(8'h30 + i));
        chk("pg_level5", 32'(level), 32'd5);

        // Put+get at full: get wins, put refused.
        cyc(0, 0, 1, 8'h00);
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(8'h40 + i));
        cyc(1, 1, 0, 8'hEE);
        chk("pg_full_level", 32'(level), 32'd15);
        chk("pg_full_ovr", 32'(overrun), 32'd1);
        chk("pg_full_out", 32'(out), 32'h40);

        // Put+get at empty: put wins, get refused.
        cyc(0, 0, 1, 8'h00);
        cyc(1, 1, 0, 8'h5A);
        chk("pg_empty_level", 32'(level), 32'd1);
        chk("pg_empty_und", 32'(underrun), 32'd1);

        // Wrap-around stream at constant level 3.
        cyc(0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'(8'h80 + i));
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 0, 8'(8'hC0 + i));
            chk("wrap_level", 32'(level), 32'd3);
            chk("wrap_data", 32'(out), (i < 3) ? 32'(8'h80 + i) : 32'(8'hC0 + i - 3));
        end

        // Flush with put at level 9 and overrun set.
        cyc(0, 0, 1, 8'h00);
        for (int i = 0; i < 17; i++) cyc(1, 0, 0, 8'(8'hA0 + i));
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 8'h00);
        chk("pre_flush_level", 32'(level), 32'd9);
        chk("pre_flush_ovr", 32'(overrun), 32'd1);
        cyc(1, 0, 1, 8'h77);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_ovr", 32'(overrun), 32'd0);

        // Refill to 6 then pulse reset between edges.
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'(8'hD0 + i));
        chk("refill_level", 32'(level), 32'd6);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_level", 32'(level), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        chk("async_rst_out", 32'(out), 32'd0);
        #1;
        reset = 1'b0;
        model_reset();
        cyc(0, 0, 0, 8'h00);

        // FWFT instance: head word visible without get.
        f1_in  = 8'hA5;
        f1_put = 1'b1;
        @(posedge clock);
        #1;
        f1_put = 1'b0;
        chk("fwft_empty", 32'(f1_empty), 32'd0);
        chk("fwft_out", 32'(f1_out), 32'hA5);
        @(posedge clock);
        #1;
        chk("fwft_hold", 32'(f1_out), 32'hA5);
        f1_get = 1'b1;
        @(posedge clock);
        #1;
        f1_get = 1'b0;
        chk("fwft_pop_empty", 32'(f1_empty), 32'd1);
        chk("fwft_pop_und", 32'(f1_underrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
